// File: rtl/period_meter_pkg.sv
// Shared constants and state encoding for the period meter.
package period_meter_pkg;

  localparam int unsigned DEF_CNT_W       = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARM     = ST_ARM,
    MEASURE = ST_MEASURE
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser chain for an asynchronous level, with registered
// rising/falling edge pulses and a level copy aligned to those pulses.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic              rise_q;
  logic              fall_q;

  // Synchroniser shift, delayed copy of last stage, and edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~dly_q;
      fall_q <= ~sync_q[STAGES-1] & dly_q;
    end
  end

  // dly_q rises in the same cycle the rise pulse is presented.
  assign level_o = dly_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/period_meter.sv
// Period meter: counts clk cycles between consecutive rising edges of a
// slow asynchronous signal, strobes each result, flags saturation.
// Optional high-phase measurement enabled by defining PERIOD_METER_DUTY_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             ovf,
  output logic [CNT_W-1:0] high_time
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic sync_level;
  logic sync_rise;
  logic sync_fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             vld_q, vld_d;
  logic             ovf_q, ovf_d;

  logic clear_c;
  logic load_c;
  logic inc_c;
  logic commit_c;
  logic sat_c;

  sync_edge_det #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (sig_in),
    .level_o (sync_level),
    .rise_o  (sync_rise),
    .fall_o  (sync_fall)
  );

  // Falling edge is not needed here; level only in the duty build.
  logic unused_sync;
  assign unused_sync = &{1'b0, sync_fall, sync_level};

  // Next-state, counter control and result update.
  always_comb begin
    state_d  = state_q;
    clear_c  = 1'b0;
    load_c   = 1'b0;
    inc_c    = 1'b0;
    commit_c = 1'b0;
    sat_c    = 1'b0;

    if (!en) begin
      state_d = IDLE;
      clear_c = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clear_c = 1'b1;
          state_d = ARM;
        end
        ARM: begin
          if (sync_rise) begin
            load_c  = 1'b1;
            state_d = MEASURE;
          end else begin
            clear_c = 1'b1;
          end
        end
        MEASURE: begin
          // A rise on the saturation cycle still yields a valid period.
          if (sync_rise) begin
            commit_c = 1'b1;
            load_c   = 1'b1;
          end else if (cnt_q == CNT_MAX) begin
            sat_c   = 1'b1;
            clear_c = 1'b1;
            state_d = ARM;
          end else begin
            inc_c = 1'b1;
          end
        end
        default: begin
          clear_c = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    cnt_d = cnt_q;
    if (clear_c) begin
      cnt_d = '0;
    end else if (load_c) begin
      cnt_d = CNT_W'(1);
    end else if (inc_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    period_d = commit_c ? cnt_q : period_q;
    vld_d    = commit_c;
    ovf_d    = ovf_q;
    if (commit_c) begin
      ovf_d = 1'b0;
    end else if (sat_c) begin
      ovf_d = 1'b1;
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
    end
  end

  assign period     = period_q;
  assign period_vld = vld_q;
  assign ovf        = ovf_q;

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_q, high_d;

  // High-phase counter follows the period counter's clear/load/step.
  always_comb begin
    hcnt_d = hcnt_q;
    if (clear_c) begin
      hcnt_d = '0;
    end else if (load_c) begin
      hcnt_d = CNT_W'(1);
    end else if (inc_c && sync_level) begin
      hcnt_d = hcnt_q + CNT_W'(1);
    end
    high_d = commit_c ? hcnt_q : high_q;
  end

  // High-phase counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q <= '0;
      high_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      high_q <= high_d;
    end
  end

  assign high_time = high_q;
`else
  assign high_time = '0;
`endif

endmodule
